imem_loader: RTL and testbench

Writer side of the instruction memory that the core fetches from. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes the words sequentially into instruction RAM and holds the core in reset until a checksummed image is fully loaded. It sits between a host byte source (UART/testbench) and the instruction RAM write port (we/addr/din).

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_byte_packer.sv | 41 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// State encoding and the default load address shared with the core's PC reset.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // Byte address of the first instruction; also the core's PC after reset
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Byte address of word number idx in an image starting at base
    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte word assembler with a running XOR checksum.
// word_next is the word as it will look once the current byte is shifted in.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        csum_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_valid,
    output logic [7:0]  checksum
);

    logic [31:0] sr;
    logic [1:0]  byte_idx;

    // Newest byte enters at the top so the first byte ends in bits 7:0
    assign word_next  = {byte_in, sr[31:8]};
    assign word_valid = accept && (byte_idx == 2'd3);

    // Shift register, byte position and checksum update on each accepted byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr       <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (clear) begin
            sr       <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (accept) begin
            sr       <= word_next;
            byte_idx <= byte_idx + 2'd1;
            if (csum_en) begin
                checksum <= checksum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: length header, data words, XOR checksum.
// Writes words to instruction RAM and holds the core in reset until verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             core_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    state_t      state;
    logic [31:0] len;

    logic        xfer;
    logic        idle_like;
    logic        pk_clear;
    logic        pk_accept;
    logic        pk_csum_en;
    logic [31:0] pk_word_next;
    logic        pk_word_valid;
    logic [7:0]  pk_checksum;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) ||
                       (state == S_ERROR);

    assign pk_clear   = start && idle_like;
    assign pk_accept  = xfer && ((state == S_LEN) || (state == S_DATA));
    assign pk_csum_en = (state == S_DATA);

    // The word being completed now is the last one of the image
    assign last_word = (32'(words_loaded) + 32'd1) == len;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .csum_en    (pk_csum_en),
        .byte_in    (in_data),
        .word_next  (pk_word_next),
        .word_valid (pk_word_valid),
        .checksum   (pk_checksum)
    );

    // Loader FSM with registered handshake, RAM write port and status
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            len          <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN;
                        in_ready     <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                S_LEN: begin
                    if (pk_accept && pk_word_valid) begin
                        len <= pk_word_next;
                        if (pk_word_next > MAX_LEN) begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (pk_word_next == 32'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (pk_accept && pk_word_valid) begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= pk_word_next;
                        mem_addr     <= word_addr(BASE_ADDR,
                                                  32'(words_loaded));
                        words_loaded <= words_loaded + CNT_W'(1);
                        if (last_word) begin
                            in_ready <= 1'b0;
                        end
                    end else if (mem_we && !in_ready) begin
                        // final write strobe is out; take the checksum
                        state    <= S_CSUM;
                        in_ready <= 1'b1;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == pk_checksum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a reference model of the image format.
// Expected writes and status are derived from the image, not from the DUT.
module tb_imem_loader;

    localparam int          MAXW  = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] img[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  last_cs;
    bit          prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_csum();
        logic [7:0] c = 8'h00;
        for (int i = 0; i < img.size(); i++)
            for (int b = 0; b < 4; b++)
                c ^= img[i][8*b +: 8];
        return c;
    endfunction

    // Every write strobe must match the next expected write, never back-to-back
    always @(negedge clk) begin
        if (rst) begin
            chk("hold_vs_done", {31'b0, core_hold}, {31'b0, ~done});
            if (mem_we) begin
                chk("we_not_consecutive", {31'b0, prev_we}, 32'd0);
                checks++;
                if (q_addr.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_we: addr %h data %h, none expected",
                             mem_addr, mem_wdata);
                end else begin
                    chk("wr_addr", mem_addr, q_addr.pop_front());
                    chk("wr_data", mem_wdata, q_data.pop_front());
                end
            end
            prev_we = mem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 100;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout: in_ready stuck low, byte %h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit with_valid);
        start = 1'b1;
        if (with_valid) begin
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [31:0] len,
                            input logic [7:0] csum_delta, input bit gaps,
                            input bit mid_start, input bit start_valid);
        bit len_ok;
        bit pass;
        int nw;
        int k;
        len_ok  = (len <= 32'(MAXW));
        nw      = len_ok ? int'(len) : 0;
        last_cs = model_csum();
        pass    = len_ok && (csum_delta == 8'h00);
        for (int i = 0; i < nw; i++) begin
            q_addr.push_back(BASE + 32'(4 * i));
            q_data.push_back(img[i]);
        end
        pulse_start(start_valid);
        for (int b = 0; b < 4; b++) send_byte(len[8*b +: 8], gaps);
        if (len_ok) begin
            k = 0;
            for (int i = 0; i < nw; i++)
                for (int b = 0; b < 4; b++) begin
                    send_byte(img[i][8*b +: 8], gaps);
                    k++;
                    if (mid_start && k == 6) pulse_start(1'b0);
                end
            send_byte(last_cs ^ csum_delta, gaps);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, {31'b0, done}, {31'b0, pass});
        chk({tag, "_error"}, {31'b0, error}, {31'b0, ~pass});
        chk({tag, "_hold"}, {31'b0, core_hold}, {31'b0, ~pass});
        chk({tag, "_words"}, {16'b0, words_loaded}, 32'(nw));
        chk({tag, "_writes_left"}, 32'(q_addr.size()), 32'd0);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_hold"}, {31'b0, core_hold}, 32'd1);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
        chk({tag, "_words"}, {16'b0, words_loaded}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state("rst0");
        rst = 1'b1;
        @(negedge clk);

        // 1: two-word image, correct checksum
        img = '{32'h0010_0513, 32'h0020_0593};
        run_load("t1", 32'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t1_model_csum", {24'b0, last_cs}, 32'h0000_00B0);
        chk("t1_words_lit", {16'b0, words_loaded}, 32'd2);

        // 2: same image, checksum off by one
        run_load("t2", 32'd2, 8'h01, 1'b0, 1'b0, 1'b0);

        // 3: length one above the maximum
        img = {};
        run_load("t3", 32'h0000_0101, 8'h00, 1'b0, 1'b0, 1'b0);

        // 3b: length with upper bits set must also fail
        run_load("t3b", 32'h0001_0000, 8'h00, 1'b0, 1'b0, 1'b0);

        // 4: empty image; start coincides with a valid byte that must be dropped
        run_load("t4a", 32'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t4a_model_csum", {24'b0, last_cs}, 32'd0);
        run_load("t4b", 32'd0, 8'h01, 1'b0, 1'b0, 1'b0);

        // 5: stalled stream with a start pulse mid-image
        img = '{32'h0010_0513, 32'h0020_0593, 32'hDEAD_BEEF};
        run_load("t5", 32'd3, 8'h00, 1'b1, 1'b1, 1'b0);

        // 6: reset after 5 data bytes, then a fresh one-word image
        img = '{32'h0010_0513, 32'h0020_0593};
        q_addr.push_back(BASE);
        q_data.push_back(img[0]);
        pulse_start(1'b0);
        for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 2 : 0), 1'b0);
        for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b0);
        send_byte(img[1][7:0], 1'b0);
        chk("t6_partial_words", {16'b0, words_loaded}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_state("t6_rst");
        chk("t6_partial_writes_left", 32'(q_addr.size()), 32'd0);
        repeat (4) @(negedge clk);
        img = '{32'h0000_0013};
        run_load("t6", 32'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_words_lit", {16'b0, words_loaded}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 checks, fails);
        $finish;
    end

endmodule
